control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle Moore FSM that sequences the MIPS datapath.
- Receives opcode/funct from the instruction register and the ALU flags.
- Drives every write enable and mux select consumed by the datapath; it is the controlling end of the datapath's control interface.
- Covers a reduced ISA plus overflow and unknown-opcode exceptions, with configurable memory wait states.

Parameters:
- MEM_WAIT, 1: cycles a memory read must be held before data is valid (1..7).
- STACK_INIT_REG, 29: register written with the initial stack value in ST_RESET.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 forces ST_RESET
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- overflow  in  1  ALU overflow, combinational
- zero  in  1  ALU zero flag
- lt  in  1  ALU less-than flag
- pc_write, pc_write_cond, mem_write, ir_write, reg_write, epc_write, ab_write, alu_out_write, mdr_write  out  1 each  write enables
- iord  out  3  memory address: 0 PC, 1 ALUOut, 2 const 253, 3 const 254
- alu_src_a  out  2  0 PC, 1 A
- alu_src_b  out  2  0 B, 1 const 4, 2 signext imm, 3 signext imm<<2
- alu_op  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare
- pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump target, 3 zero-extended MDR[7:0]
- reg_dst  out  3  0 rt, 1 rd, 2 r31, 3 r29
- mem_to_reg  out  4  0 ALUOut, 1 MDR, 2 SE1_32(lt), 3 const 227
- branch_ne  out  1  1 selects the !zero branch condition
- state  out  5  current state, for debug

Behaviour:
- Outputs are a pure function of state; transitions are evaluated on the rising edge. On reset: state=ST_RESET. Every output not listed for a state is 0.
- ST_RESET: reg_dst=3, mem_to_reg=3, reg_write=1 (r29<=227) -> FETCH.
- FETCH: iord=0, wait counter runs MEM_WAIT cycles -> IR_LOAD.
- IR_LOAD: ir_write=1; PC<=PC+4 (src_a 0, src_b 1, add, pc_source 0, pc_write) -> DECODE.
- DECODE: ab_write=1; ALUOut<=PC+(imm<<2) (src_b 3, add, alu_out_write). Dispatch:
  - op 0x00, funct 0x20/0x22/0x24/0x2A -> EXEC_R
  - op 0x00, funct 0x08 -> JR
  - op 0x08 -> EXEC_I
  - op 0x23 / 0x2B -> ADDR
  - op 0x04 / 0x05 -> BRANCH
  - op 0x02 -> JUMP
  - op 0x03 -> JAL_1
  - anything else -> EXC_EPC with cause OPC
- EXEC_R: src_a 1, src_b 0, alu_op from funct, alu_out_write.
  - overflow and funct add/sub -> EXC_EPC (cause OVF)
  - slt -> WB_SLT
  - otherwise -> WB_R
- WB_R: reg_dst 1, mem_to_reg 0, reg_write -> FETCH.
- WB_SLT: keeps the EXEC_R ALU selects; mem_to_reg 2, reg_dst 1, reg_write -> FETCH.
- EXEC_I: src_a 1, src_b 2, add, alu_out_write. Overflow -> EXC_EPC (OVF), else WB_I.
- WB_I: reg_dst 0, mem_to_reg 0, reg_write -> FETCH.
- ADDR: A+imm into ALUOut -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord 1 for MEM_WAIT cycles; mdr_write on the last cycle -> WB_LW.
- WB_LW: reg_dst 0, mem_to_reg 1, reg_write -> FETCH.
- MEM_WR: iord 1, mem_write for exactly 1 cycle -> FETCH.
- BRANCH: src_a 1, src_b 0, sub, pc_source 1, pc_write_cond, branch_ne=(opcode==0x05) -> FETCH.
- JUMP: pc_source 2, pc_write -> FETCH.
- JAL_1: src_a 0, alu_op 000, alu_out_write (ALUOut<=PC) -> JAL_2.
- JAL_2: reg_dst 2, mem_to_reg 0, reg_write, pc_source 2, pc_write -> FETCH.
- JR: src_a 1, alu_op 000, pc_source 0, pc_write -> FETCH.
- EXC_EPC: src_a 0, src_b 1, sub, epc_write (EPC<=PC-4); cause latched in a 1-bit register -> EXC_RD.
- EXC_RD: iord 2 (OPC) or 3 (OVF) held for MEM_WAIT cycles; mdr_write on the last cycle -> EXC_PC.
- EXC_PC: pc_source 3, pc_write -> FETCH.
- Boundary conditions:
  - The wait counter clears on every entry to a wait state; MEM_WAIT=1 means a single cycle.
  - Reset low mid-instruction returns to ST_RESET asynchronously; no partial write completes after reset.
  - Overflow is ignored in every state except EXEC_R (add/sub) and EXEC_I.
  - An unreachable state code returns to ST_RESET on the next edge.

Optional Feature:
- BREAK_HALT_EN defined: funct 0x0D with op 0x00 -> HALT. HALT has all outputs 0 and is left only by reset.
- Undefined: funct 0x0D is an unknown opcode and takes the OPC exception.

Decomposition:
- Package ctrl_pkg holds:
  - the state encoding (5-bit localparams)
  - opcode and funct constants
  - iord, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg select codes
  - MEM_WAIT limits
- One sub-module, mem_wait_counter:
  - inputs: clear, enable
  - output: done after MEM_WAIT counts
  - shared by FETCH, MEM_RD and EXC_RD.

Test Plan:
- Reset released -> ST_RESET for 1 cycle with reg_write=1, reg_dst=3, mem_to_reg=3; FETCH follows.
- add (op 0, funct 0x20), MEM_WAIT=2 -> FETCH, FETCH, IR_LOAD, DECODE, EXEC_R, WB_R; reg_write=1 and reg_dst=1 in WB_R.
- lw (0x23), MEM_WAIT=3 -> mdr_write asserted only in the 3rd MEM_RD cycle, then WB_LW with mem_to_reg=1.
- addi with overflow=1 in EXEC_I -> EXC_EPC with epc_write=1, EXC_RD with iord=3, EXC_PC with pc_source=3; no reg_write.
- Opcode 0x3F -> EXC_RD with iord=2. With BREAK_HALT_EN, funct 0x0D -> HALT held 20 cycles until reset is pulled low.
- bne (0x05) -> BRANCH with pc_write_cond=1, branch_ne=1. Reset low during MEM_RD -> all enables 0 immediately.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encoding,
// opcode/funct constants, datapath select codes and memory wait limits.
package ctrl_pkg;

  localparam int MEM_WAIT_MIN = 1;
  localparam int MEM_WAIT_MAX = 7;

  // 5-bit state encoding; codes 22..31 are unreachable and recover to ST_RESET
  typedef enum logic [4:0] {
    ST_RESET   = 5'd0,
    ST_FETCH   = 5'd1,
    ST_IR_LOAD = 5'd2,
    ST_DECODE  = 5'd3,
    ST_EXEC_R  = 5'd4,
    ST_WB_R    = 5'd5,
    ST_WB_SLT  = 5'd6,
    ST_EXEC_I  = 5'd7,
    ST_WB_I    = 5'd8,
    ST_ADDR    = 5'd9,
    ST_MEM_RD  = 5'd10,
    ST_WB_LW   = 5'd11,
    ST_MEM_WR  = 5'd12,
    ST_BRANCH  = 5'd13,
    ST_JUMP    = 5'd14,
    ST_JAL_1   = 5'd15,
    ST_JAL_2   = 5'd16,
    ST_JR      = 5'd17,
    ST_EXC_EPC = 5'd18,
    ST_EXC_RD  = 5'd19,
    ST_EXC_PC  = 5'd20,
    ST_HALT    = 5'd21
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Memory address select
  localparam logic [2:0] IORD_PC      = 3'd0;
  localparam logic [2:0] IORD_ALUOUT  = 3'd1;
  localparam logic [2:0] IORD_EXC_OPC = 3'd2;
  localparam logic [2:0] IORD_EXC_OVF = 3'd3;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC      = 2'd0;
  localparam logic [1:0] SRCA_A       = 2'd1;
  localparam logic [1:0] SRCB_B       = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  // ALU operations
  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_CMP    = 3'b111;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_MDR    = 2'd3;

  // Register-file destination select
  localparam logic [2:0] RDST_RT  = 3'd0;
  localparam logic [2:0] RDST_RD  = 3'd1;
  localparam logic [2:0] RDST_R31 = 3'd2;
  localparam logic [2:0] RDST_R29 = 3'd3;

  // Register-file write-data select
  localparam logic [3:0] MTR_ALUOUT = 4'd0;
  localparam logic [3:0] MTR_MDR    = 4'd1;
  localparam logic [3:0] MTR_LT     = 4'd2;
  localparam logic [3:0] MTR_CONST  = 4'd3;

  // Exception cause held across EXC_EPC/EXC_RD
  localparam logic CAUSE_OPC = 1'b0;
  localparam logic CAUSE_OVF = 1'b1;

  // ALU operation implied by a supported R-type funct
  function automatic logic [2:0] alu_op_for_funct(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_SLT:  op = ALU_CMP;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit_mem_wait_counter.sv
// Memory wait-state counter shared by FETCH, MEM_RD and EXC_RD.
// done rises in the MEM_WAIT-th consecutive enabled cycle after a clear.
module mem_wait_counter
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  // Out-of-range MEM_WAIT is clamped to the supported 1..7 window
  localparam int WAIT_CYCLES = (MEM_WAIT < MEM_WAIT_MIN) ? MEM_WAIT_MIN :
                               (MEM_WAIT > MEM_WAIT_MAX) ? MEM_WAIT_MAX : MEM_WAIT;
  localparam logic [2:0] LAST_COUNT = 3'(WAIT_CYCLES - 1);

  logic [2:0] count_q;
  logic [2:0] count_d;

  assign done = enable && (count_q == LAST_COUNT);

  // Next count: clear wins, otherwise advance while waiting
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !done) begin
      count_d = count_q + 3'd1;
    end
  end

  // Count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore control unit for the reduced MIPS datapath.
// Optional feature macro: BREAK_HALT_EN (BREAK, op 0x00 funct 0x0D, halts
// the machine until reset; otherwise it raises the unknown-opcode exception).
// While reset is low every output is forced to 0 so no datapath write can
// happen during reset; the ST_RESET stack-init write occurs in the first
// cycle after release.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT       = 1,
  parameter int STACK_INIT_REG = 29
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  input  logic       lt,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       epc_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       mdr_write,
  output logic [2:0] iord,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic [2:0] reg_dst,
  output logic [3:0] mem_to_reg,
  output logic       branch_ne,
  output logic [4:0] state
);

  // The datapath only has fixed r29/r31 destinations; r31 is used when the
  // stack register is configured as 31, r29 otherwise.
  localparam logic [2:0] RDST_STACK = (STACK_INIT_REG == 31) ? RDST_R31 : RDST_R29;

  state_e state_q, state_d;
  logic   cause_q, cause_d;
  logic   wait_state;
  logic   wait_clear;
  logic   wait_done;

  // zero/lt feed branch resolution and slt write-back inside the datapath
  logic unused_flags;
  assign unused_flags = zero | lt;

  assign state      = state_q;
  assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                      (state_q == ST_EXC_RD);
  // Counter restarts whenever the FSM is outside a wait state or leaving one,
  // so every entry to a wait state starts from zero.
  assign wait_clear = !wait_state || wait_done;

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clock (clock),
    .reset (reset),
    .clear (wait_clear),
    .enable(wait_state),
    .done  (wait_done)
  );

  // Next-state and exception-cause selection
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_RESET:   state_d = ST_FETCH;
      ST_FETCH:   if (wait_done) state_d = ST_IR_LOAD;
      ST_IR_LOAD: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND, FN_SLT: state_d = ST_EXEC_R;
              FN_JR:                          state_d = ST_JR;
`ifdef BREAK_HALT_EN
              FN_BREAK:                       state_d = ST_HALT;
`endif
              default: begin
                state_d = ST_EXC_EPC;
                cause_d = CAUSE_OPC;
              end
            endcase
          end
          OP_ADDI:      state_d = ST_EXEC_I;
          OP_LW, OP_SW: state_d = ST_ADDR;
          OP_BEQ, OP_BNE: state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_JAL:       state_d = ST_JAL_1;
          default: begin
            state_d = ST_EXC_EPC;
            cause_d = CAUSE_OPC;
          end
        endcase
      end
      ST_EXEC_R: begin
        if (overflow && ((funct == FN_ADD) || (funct == FN_SUB))) begin
          state_d = ST_EXC_EPC;
          cause_d = CAUSE_OVF;
        end else if (funct == FN_SLT) begin
          state_d = ST_WB_SLT;
        end else begin
          state_d = ST_WB_R;
        end
      end
      ST_EXEC_I: begin
        if (overflow) begin
          state_d = ST_EXC_EPC;
          cause_d = CAUSE_OVF;
        end else begin
          state_d = ST_WB_I;
        end
      end
      ST_ADDR:    state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:  if (wait_done) state_d = ST_WB_LW;
      ST_JAL_1:   state_d = ST_JAL_2;
      ST_EXC_EPC: state_d = ST_EXC_RD;
      ST_EXC_RD:  if (wait_done) state_d = ST_EXC_PC;
      ST_WB_R, ST_WB_SLT, ST_WB_I, ST_WB_LW, ST_MEM_WR, ST_BRANCH,
      ST_JUMP, ST_JAL_2, ST_JR, ST_EXC_PC: state_d = ST_FETCH;
`ifdef BREAK_HALT_EN
      ST_HALT:    state_d = ST_HALT;
`endif
      default:    state_d = ST_RESET;
    endcase
  end

  // State and cause registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RESET;
      cause_q <= CAUSE_OPC;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Moore output decode; everything is 0 unless the state names it
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    epc_write     = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    iord          = IORD_PC;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_PASS_A;
    pc_source     = PCSRC_ALU;
    reg_dst       = RDST_RT;
    mem_to_reg    = MTR_ALUOUT;
    branch_ne     = 1'b0;
    if (reset) begin
      case (state_q)
        ST_RESET: begin
          reg_dst    = RDST_STACK;
          mem_to_reg = MTR_CONST;
          reg_write  = 1'b1;
        end
        ST_FETCH: iord = IORD_PC;
        ST_IR_LOAD: begin
          ir_write  = 1'b1;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          pc_source = PCSRC_ALU;
          pc_write  = 1'b1;
        end
        ST_DECODE: begin
          ab_write      = 1'b1;
          alu_src_a     = SRCA_PC;
          alu_src_b     = SRCB_IMM_SH2;
          alu_op        = ALU_ADD;
          alu_out_write = 1'b1;
        end
        ST_EXEC_R: begin
          alu_src_a     = SRCA_A;
          alu_src_b     = SRCB_B;
          alu_op        = alu_op_for_funct(funct);
          alu_out_write = 1'b1;
        end
        ST_WB_R: begin
          reg_dst    = RDST_RD;
          mem_to_reg = MTR_ALUOUT;
          reg_write  = 1'b1;
        end
        ST_WB_SLT: begin
          alu_src_a  = SRCA_A;
          alu_src_b  = SRCB_B;
          alu_op     = alu_op_for_funct(funct);
          mem_to_reg = MTR_LT;
          reg_dst    = RDST_RD;
          reg_write  = 1'b1;
        end
        ST_EXEC_I, ST_ADDR: begin
          alu_src_a     = SRCA_A;
          alu_src_b     = SRCB_IMM;
          alu_op        = ALU_ADD;
          alu_out_write = 1'b1;
        end
        ST_WB_I: begin
          reg_dst    = RDST_RT;
          mem_to_reg = MTR_ALUOUT;
          reg_write  = 1'b1;
        end
        ST_MEM_RD: begin
          iord      = IORD_ALUOUT;
          mdr_write = wait_done;
        end
        ST_WB_LW: begin
          reg_dst    = RDST_RT;
          mem_to_reg = MTR_MDR;
          reg_write  = 1'b1;
        end
        ST_MEM_WR: begin
          iord      = IORD_ALUOUT;
          mem_write = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a     = SRCA_A;
          alu_src_b     = SRCB_B;
          alu_op        = ALU_SUB;
          pc_source     = PCSRC_ALUOUT;
          pc_write_cond = 1'b1;
          branch_ne     = (opcode == OP_BNE);
        end
        ST_JUMP: begin
          pc_source = PCSRC_JUMP;
          pc_write  = 1'b1;
        end
        ST_JAL_1: begin
          alu_src_a     = SRCA_PC;
          alu_op        = ALU_PASS_A;
          alu_out_write = 1'b1;
        end
        ST_JAL_2: begin
          reg_dst    = RDST_R31;
          mem_to_reg = MTR_ALUOUT;
          reg_write  = 1'b1;
          pc_source  = PCSRC_JUMP;
          pc_write   = 1'b1;
        end
        ST_JR: begin
          alu_src_a = SRCA_A;
          alu_op    = ALU_PASS_A;
          pc_source = PCSRC_ALU;
          pc_write  = 1'b1;
        end
        ST_EXC_EPC: begin
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_SUB;
          epc_write = 1'b1;
        end
        ST_EXC_RD: begin
          iord      = (cause_q == CAUSE_OVF) ? IORD_EXC_OVF : IORD_EXC_OPC;
          mdr_write = wait_done;
        end
        ST_EXC_PC: begin
          pc_source = PCSRC_MDR;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: a table of instruction vectors, each
// expanded into an expected per-cycle output sequence pushed onto a
// scoreboard queue and popped as the DUT steps, plus hand-written sequences
// for async reset mid-read and (with BREAK_HALT_EN) the HALT state.
module tb_control_unit;
  import ctrl_pkg::*;

  localparam int MEM_WAIT = 3;
  localparam int W        = 34;

  // Enable bit positions in {pc_write .. mdr_write}
  localparam logic [8:0] E_PC  = 9'h100;
  localparam logic [8:0] E_PWC = 9'h080;
  localparam logic [8:0] E_MW  = 9'h040;
  localparam logic [8:0] E_IR  = 9'h020;
  localparam logic [8:0] E_RW  = 9'h010;
  localparam logic [8:0] E_EPC = 9'h008;
  localparam logic [8:0] E_AB  = 9'h004;
  localparam logic [8:0] E_AO  = 9'h002;
  localparam logic [8:0] E_MDR = 9'h001;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [5:0] opcode, funct;
  logic       overflow, zero, lt;
  logic       pc_write, pc_write_cond, mem_write, ir_write, reg_write;
  logic       epc_write, ab_write, alu_out_write, mdr_write;
  logic [2:0] iord, alu_op, reg_dst;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic [3:0] mem_to_reg;
  logic       branch_ne;
  logic [4:0] state;

  control_unit #(
    .MEM_WAIT      (MEM_WAIT),
    .STACK_INIT_REG(29)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .opcode       (opcode),
    .funct        (funct),
    .overflow     (overflow),
    .zero         (zero),
    .lt           (lt),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .epc_write    (epc_write),
    .ab_write     (ab_write),
    .alu_out_write(alu_out_write),
    .mdr_write    (mdr_write),
    .iord         (iord),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .pc_source    (pc_source),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .branch_ne    (branch_ne),
    .state        (state)
  );

  logic [W-1:0] dut_word;
  assign dut_word = {state, pc_write, pc_write_cond, mem_write, ir_write, reg_write,
                     epc_write, ab_write, alu_out_write, mdr_write, iord, alu_src_a,
                     alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, branch_ne};

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_applied    = 0;
  int n_miscompares = 0;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       ovf;
    logic       cause;   // 1 = overflow exception, 0 = opcode exception
    int         n;
    state_e     path[4]; // states after DECODE; wait states listed once
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkvec(input string name, input logic [5:0] op, input logic [5:0] fn,
                                 input logic ovf, input logic cause, input int n,
                                 input state_e p0, input state_e p1 = ST_RESET,
                                 input state_e p2 = ST_RESET, input state_e p3 = ST_RESET);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.ovf = ovf; v.cause = cause; v.n = n;
    v.path[0] = p0; v.path[1] = p1; v.path[2] = p2; v.path[3] = p3;
    return v;
  endfunction

  // Expected outputs for one cycle in state st
  function automatic logic [W-1:0] word(input state_e st, input logic [5:0] op, input logic [5:0] fn,
                                        input logic cause, input logic last);
    logic [8:0] en;
    logic [2:0] io, aop, rd;
    logic [1:0] sa, sb, ps;
    logic [3:0] mtr;
    logic       bne;
    en = '0; io = '0; aop = '0; rd = '0; sa = '0; sb = '0; ps = '0; mtr = '0; bne = 1'b0;
    case (st)
      ST_RESET:   begin en = E_RW; rd = 3'd3; mtr = 4'd3; end
      ST_IR_LOAD: begin en = E_IR | E_PC; sb = 2'd1; aop = 3'b001; end
      ST_DECODE:  begin en = E_AB | E_AO; sb = 2'd3; aop = 3'b001; end
      ST_EXEC_R, ST_WB_SLT: begin
        sa  = 2'd1;
        aop = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 :
              (fn == 6'h24) ? 3'b011 : 3'b111;
        if (st == ST_EXEC_R) en = E_AO;
        else begin en = E_RW; mtr = 4'd2; rd = 3'd1; end
      end
      ST_WB_R:    begin en = E_RW; rd = 3'd1; end
      ST_EXEC_I, ST_ADDR: begin en = E_AO; sa = 2'd1; sb = 2'd2; aop = 3'b001; end
      ST_WB_I:    en = E_RW;
      ST_MEM_RD:  begin io = 3'd1; en = last ? E_MDR : 9'h000; end
      ST_WB_LW:   begin en = E_RW; mtr = 4'd1; end
      ST_MEM_WR:  begin io = 3'd1; en = E_MW; end
      ST_BRANCH:  begin en = E_PWC; sa = 2'd1; aop = 3'b010; ps = 2'd1; bne = (op == 6'h05); end
      ST_JUMP:    begin en = E_PC; ps = 2'd2; end
      ST_JAL_1:   en = E_AO;
      ST_JAL_2:   begin en = E_RW | E_PC; rd = 3'd2; ps = 2'd2; end
      ST_JR:      begin en = E_PC; sa = 2'd1; end
      ST_EXC_EPC: begin en = E_EPC; sb = 2'd1; aop = 3'b010; end
      ST_EXC_RD:  begin io = cause ? 3'd3 : 3'd2; en = last ? E_MDR : 9'h000; end
      ST_EXC_PC:  begin en = E_PC; ps = 2'd3; end
      default: ;
    endcase
    return {5'(st), en, io, sa, sb, aop, ps, rd, mtr, bne};
  endfunction

  // State shown while reset is held: every output forced to 0
  function automatic logic [W-1:0] held_word();
    return {5'(ST_RESET), 29'b0};
  endfunction

  // driver tasks
  task automatic push_state(input state_e st, input vec_t v);
    if (st == ST_MEM_RD || st == ST_EXC_RD || st == ST_FETCH) begin
      for (int k = 0; k < MEM_WAIT; k++)
        exp_q.push_back(word(st, v.op, v.fn, v.cause, k == MEM_WAIT - 1));
    end else begin
      exp_q.push_back(word(st, v.op, v.fn, v.cause, 1'b0));
    end
  endtask

  task automatic push_front_end(input vec_t v);
    push_state(ST_FETCH, v);
    push_state(ST_IR_LOAD, v);
    push_state(ST_DECODE, v);
  endtask

  task automatic check(input string tag);
    logic [W-1:0] e;
    n_applied++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got state=%0d outs=%h", tag,
               dut_word[W-1 -: 5], dut_word[W-6:0]);
      n_miscompares++;
    end else begin
      e = exp_q.pop_front();
      if (dut_word !== e) begin
        $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h", tag,
                 dut_word[W-1 -: 5], dut_word[W-6:0], e[W-1 -: 5], e[W-6:0]);
        n_miscompares++;
      end
    end
  endtask

  task automatic step_check(input string tag);
    @(negedge clock);
    zero = 1'($urandom_range(0, 1));
    lt   = 1'($urandom_range(0, 1));
    check(tag);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) step_check(tag);
  endtask

  task automatic apply(input vec_t v);
    opcode   = v.op;
    funct    = v.fn;
    overflow = v.ovf;
    push_front_end(v);
    for (int i = 0; i < v.n; i++) push_state(v.path[i], v);
    drain(v.name);
  endtask

  task automatic release_reset(input vec_t v);
    reset = 1'b1;
    #1;
    exp_q.push_back(word(ST_RESET, v.op, v.fn, 1'b0, 1'b0));
    check("reset_release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    opcode = '0; funct = '0; overflow = 1'b0; zero = 1'b0; lt = 1'b0;

    vecs.push_back(mkvec("add",       6'h00, 6'h20, 1'b0, 1'b0, 2, ST_EXEC_R, ST_WB_R));
    vecs.push_back(mkvec("sub_ovf",   6'h00, 6'h22, 1'b1, 1'b1, 4, ST_EXEC_R, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));
    vecs.push_back(mkvec("sub",       6'h00, 6'h22, 1'b0, 1'b0, 2, ST_EXEC_R, ST_WB_R));
    vecs.push_back(mkvec("and_ovf",   6'h00, 6'h24, 1'b1, 1'b0, 2, ST_EXEC_R, ST_WB_R));
    vecs.push_back(mkvec("slt_ovf",   6'h00, 6'h2A, 1'b1, 1'b0, 2, ST_EXEC_R, ST_WB_SLT));
    vecs.push_back(mkvec("jr_ovf",    6'h00, 6'h08, 1'b1, 1'b0, 1, ST_JR));
    vecs.push_back(mkvec("addi",      6'h08, 6'h15, 1'b0, 1'b0, 2, ST_EXEC_I, ST_WB_I));
    vecs.push_back(mkvec("addi_ovf",  6'h08, 6'h15, 1'b1, 1'b1, 4, ST_EXEC_I, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));
    vecs.push_back(mkvec("lw_ovf",    6'h23, 6'h00, 1'b1, 1'b0, 3, ST_ADDR, ST_MEM_RD, ST_WB_LW));
    vecs.push_back(mkvec("sw",        6'h2B, 6'h3F, 1'b0, 1'b0, 2, ST_ADDR, ST_MEM_WR));
    vecs.push_back(mkvec("beq",       6'h04, 6'h00, 1'b0, 1'b0, 1, ST_BRANCH));
    vecs.push_back(mkvec("bne",       6'h05, 6'h00, 1'b1, 1'b0, 1, ST_BRANCH));
    vecs.push_back(mkvec("j",         6'h02, 6'h00, 1'b0, 1'b0, 1, ST_JUMP));
    vecs.push_back(mkvec("jal",       6'h03, 6'h00, 1'b1, 1'b0, 2, ST_JAL_1, ST_JAL_2));
    vecs.push_back(mkvec("op3f",      6'h3F, 6'h20, 1'b1, 1'b0, 3, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));
    vecs.push_back(mkvec("rtype_bad", 6'h00, 6'h3F, 1'b0, 1'b0, 3, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));
`ifndef BREAK_HALT_EN
    vecs.push_back(mkvec("break_opc", 6'h00, 6'h0D, 1'b0, 1'b0, 3, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));
`endif
    vecs.push_back(mkvec("add_after", 6'h00, 6'h20, 1'b1, 1'b1, 4, ST_EXEC_R, ST_EXC_EPC, ST_EXC_RD, ST_EXC_PC));

    // Reset held: ST_RESET with every output 0
    #3 reset = 1'b0;
    @(negedge clock);
    exp_q.push_back(held_word());
    check("reset_held");
    @(negedge clock);
    release_reset(vecs[0]);

    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulled low in the first MEM_RD cycle of a lw
    v = vecs[8];
    opcode = v.op; funct = v.fn; overflow = v.ovf;
    push_front_end(v);
    push_state(ST_ADDR, v);
    exp_q.push_back(word(ST_MEM_RD, v.op, v.fn, 1'b0, 1'b0));
    drain("lw_to_mem_rd");
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(held_word());
    check("async_reset_mem_rd");
    @(negedge clock);
    exp_q.push_back(held_word());
    check("reset_held_mem_rd");
    release_reset(vecs[0]);
    apply(vecs[0]);

`ifdef BREAK_HALT_EN
    // BREAK halts until reset
    v = mkvec("break_halt", 6'h00, 6'h0D, 1'b0, 1'b0, 0, ST_HALT);
    opcode = v.op; funct = v.fn; overflow = 1'b0;
    push_front_end(v);
    for (int k = 0; k < 20; k++) exp_q.push_back(word(ST_HALT, v.op, v.fn, 1'b0, 1'b0));
    drain("halt");
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(held_word());
    check("halt_reset");
    @(negedge clock);
    release_reset(vecs[0]);
    apply(vecs[0]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
